fp_add_ctrl: RTL and testbench

Multi-cycle sequencer for the single-precision floating-point adder datapath. It loads both operand PIPO registers and compares their exponents. It then steps the mantissa-alignment shifter, fires the adder and steps the normalizer, and finally writes the result register. Requesters talk to it through a start/ready and out_valid/out_ready handshake. All datapath control outputs are single-cycle strobes or held selects decoded from one FSM.

---
 rtl/fp_add_ctrl_if.sv | 72 +++++++
 rtl/fp_add_ctrl.sv | 173 +++++++++++++++++
 tb/tb_fp_add_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_add_ctrl_if.sv
// Handshake and datapath-control bundle between the FP adder sequencer
// (slave side) and its requester / datapath (master side).
interface fp_add_ctrl_if #(
    parameter int EXP_W = 8
) ();

    // Requester handshake
    logic             start;
    logic             ready;
    logic             out_valid;
    logic             out_ready;

    // Status coming back from the datapath
    logic [EXP_W-1:0] exp_a;
    logic [EXP_W-1:0] exp_b;
    logic             sum_carry;
    logic             sum_msb;
    logic             sum_zero;

    // Control strobes and selects going to the datapath
    logic             load_en;
    logic             swap_sel;
    logic             align_shift;
    logic             add_en;
    logic             norm_right;
    logic             norm_left;
    logic             special;
    logic             result_we;

    // Requester + datapath view
    modport master (
        output start,
        output out_ready,
        output exp_a,
        output exp_b,
        output sum_carry,
        output sum_msb,
        output sum_zero,
        input  ready,
        input  out_valid,
        input  load_en,
        input  swap_sel,
        input  align_shift,
        input  add_en,
        input  norm_right,
        input  norm_left,
        input  special,
        input  result_we
    );

    // Sequencer view
    modport slave (
        input  start,
        input  out_ready,
        input  exp_a,
        input  exp_b,
        input  sum_carry,
        input  sum_msb,
        input  sum_zero,
        output ready,
        output out_valid,
        output load_en,
        output swap_sel,
        output align_shift,
        output add_en,
        output norm_right,
        output norm_left,
        output special,
        output result_we
    );

endinterface

// File: rtl/fp_add_ctrl.sv
// Multi-cycle sequencer for a single-precision FP adder datapath.
// One FSM walks IDLE -> CMP -> ALIGN -> ADD -> NORM -> WRITE -> DONE and
// decodes every datapath strobe from its state. Special operands (an
// all-ones exponent) bypass the arithmetic and go straight to WRITE.
module fp_add_ctrl #(
    parameter int EXP_W     = 8,
    parameter int ALIGN_CAP = 25,
    parameter int NORM_MAX  = 23
) (
    input  logic         clk,
    input  logic         reset,
    fp_add_ctrl_if.slave bus
);

    localparam int ALIGN_W = $clog2(ALIGN_CAP + 1);
    localparam int NORM_W  = $clog2(NORM_MAX + 1);

    localparam logic [EXP_W:0]   ALIGN_CAP_X = (EXP_W + 1)'(ALIGN_CAP);
    localparam logic [ALIGN_W-1:0] ALIGN_CAP_C = ALIGN_W'(ALIGN_CAP);
    localparam logic [ALIGN_W-1:0] ALIGN_ONE   = ALIGN_W'(1);
    localparam logic [NORM_W-1:0]  NORM_MAX_C  = NORM_W'(NORM_MAX);
    localparam logic [NORM_W-1:0]  NORM_ONE    = NORM_W'(1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CMP   = 3'd1;
    localparam logic [2:0] S_ALIGN = 3'd2;
    localparam logic [2:0] S_ADD   = 3'd3;
    localparam logic [2:0] S_NORM  = 3'd4;
    localparam logic [2:0] S_WRITE = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]         state_q,     state_d;
    logic [ALIGN_W-1:0] align_cnt_q, align_cnt_d;
    logic [NORM_W-1:0]  norm_cnt_q,  norm_cnt_d;
    logic               swap_q,      swap_d;
    logic               special_q,   special_d;

    // Exponent comparison, valid while the operand registers hold the
    // freshly loaded values (CMP cycle). The difference is taken one bit
    // wider than the exponent so it can never wrap.
    logic               b_gt_a;
    logic               special_hit;
    logic [EXP_W:0]     abs_diff;
    logic [ALIGN_W-1:0] align_load;

    // Normalizer decisions shared by the next-state logic and the strobes
    logic               norm_can_left;
    logic               norm_do_right;
    logic               norm_do_left;

    // Exponent difference, saturated so a huge gap just flushes the operand
    always_comb begin
        b_gt_a      = (bus.exp_b > bus.exp_a);
        special_hit = (&bus.exp_a) | (&bus.exp_b);
        if (b_gt_a) begin
            abs_diff = {1'b0, bus.exp_b} - {1'b0, bus.exp_a};
        end else begin
            abs_diff = {1'b0, bus.exp_a} - {1'b0, bus.exp_b};
        end
        if (abs_diff > ALIGN_CAP_X) begin
            align_load = ALIGN_CAP_C;
        end else begin
            align_load = ALIGN_W'(abs_diff);
        end
    end

    // Normalize priority: zero sum beats carry, carry beats left shifts
    always_comb begin
        norm_can_left = (!bus.sum_msb) && (norm_cnt_q < NORM_MAX_C);
        norm_do_right = (state_q == S_NORM) && !bus.sum_zero && bus.sum_carry;
        norm_do_left  = (state_q == S_NORM) && !bus.sum_zero && !bus.sum_carry
                        && norm_can_left;
    end

    // Next-state and counter/flag update logic
    always_comb begin
        state_d     = state_q;
        align_cnt_d = align_cnt_q;
        norm_cnt_d  = norm_cnt_q;
        swap_d      = swap_q;
        special_d   = special_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_CMP;
                end
            end

            S_CMP: begin
                if (special_hit) begin
                    special_d = 1'b1;
                    state_d   = S_WRITE;
                end else begin
                    swap_d      = b_gt_a;
                    align_cnt_d = align_load;
                    state_d     = (align_load != '0) ? S_ALIGN : S_ADD;
                end
            end

            // Leaving on count==1 issues exactly the loaded number of shifts
            S_ALIGN: begin
                align_cnt_d = align_cnt_q - ALIGN_ONE;
                if (align_cnt_q <= ALIGN_ONE) begin
                    state_d = S_ADD;
                end
            end

            S_ADD: begin
                norm_cnt_d = '0;
                state_d    = S_NORM;
            end

            S_NORM: begin
                if (bus.sum_zero || bus.sum_carry) begin
                    state_d = S_WRITE;
                end else if (norm_can_left) begin
                    norm_cnt_d = norm_cnt_q + NORM_ONE;
                end else begin
                    state_d = S_WRITE;
                end
            end

            S_WRITE: begin
                state_d = S_DONE;
            end

            // Held selects are released together with the result handshake
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d   = S_IDLE;
                    swap_d    = 1'b0;
                    special_d = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            align_cnt_q <= '0;
            norm_cnt_q  <= '0;
            swap_q      <= 1'b0;
            special_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            align_cnt_q <= align_cnt_d;
            norm_cnt_q  <= norm_cnt_d;
            swap_q      <= swap_d;
            special_q   <= special_d;
        end
    end

    // Output decode; load_en follows start directly so the operands are
    // captured on the same edge that accepts the request
    assign bus.ready       = (state_q == S_IDLE);
    assign bus.load_en     = (state_q == S_IDLE) && bus.start;
    assign bus.align_shift = (state_q == S_ALIGN);
    assign bus.add_en      = (state_q == S_ADD);
    assign bus.norm_right  = norm_do_right;
    assign bus.norm_left   = norm_do_left;
    assign bus.result_we   = (state_q == S_WRITE);
    assign bus.out_valid   = (state_q == S_DONE);
    assign bus.swap_sel    = swap_q;
    assign bus.special     = special_q;

endmodule

// File: tb/tb_fp_add_ctrl.sv
// Directed bench for fp_add_ctrl: strobe counts, latencies, held selects,
// reset abort, ignored start while busy and held out_valid.
module tb_fp_add_ctrl;

    logic clk = 1'b0;
    logic reset;

    fp_add_ctrl_if #(.EXP_W(8)) bus ();

    fp_add_ctrl #(
        .EXP_W    (8),
        .ALIGN_CAP(25),
        .NORM_MAX (23)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    int n_load, n_align, n_add, n_nr, n_nl, n_we, n_ov;
    int we_cyc, ov_cyc, acc;
    int msb_after = 0;
    int nl_snap   = 0;
    logic swap_seen, special_seen;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe counters, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.load_en)     n_load++;
        if (bus.align_shift) n_align++;
        if (bus.add_en)      n_add++;
        if (bus.norm_right)  n_nr++;
        if (bus.norm_left)   n_nl++;
        if (bus.out_valid)   n_ov++;
        if (bus.result_we) begin
            n_we++;
            we_cyc = cyc;
        end
    end

    // Sum MSB model: the hidden bit appears after msb_after left shifts.
    // The snapshot only moves on the clock edge so the NORM decision sees
    // a stable value for the whole cycle.
    always @(posedge clk) nl_snap <= n_nl;
    assign bus.sum_msb = (nl_snap >= msb_after);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        n_load = 0; n_align = 0; n_add = 0; n_nr = 0; n_nl = 0;
        n_we = 0; n_ov = 0; we_cyc = -1; ov_cyc = -1;
    endtask

    // One complete operation; poke != 0 raises start at that offset from accept
    task automatic run_op(input logic [7:0] ea, input logic [7:0] eb,
                          input logic carry, input logic zero,
                          input int m_after, input int delay, input int poke);
        @(posedge clk); #1;
        clear_counts();
        bus.exp_a     = ea;
        bus.exp_b     = eb;
        bus.sum_carry = carry;
        bus.sum_zero  = zero;
        msb_after     = m_after;
        bus.start     = 1'b1;
        acc           = cyc;
        #1;
        chk("load_en_on_start", {31'd0, bus.load_en}, 1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.out_valid) begin
                ov_cyc = cyc;
                break;
            end
            if (poke != 0 && cyc - acc == poke) begin
                bus.start = 1'b1;
                #1;
                chk("load_en_ignored", {31'd0, bus.load_en}, 0);
                chk("ready_busy", {31'd0, bus.ready}, 0);
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        if (ov_cyc < 0) begin
            chk("out_valid_timeout", 0, 1);
        end else begin
            for (int i = 0; i < delay; i++) begin
                @(posedge clk); #1;
                chk("out_valid_held", {31'd0, bus.out_valid}, 1);
            end
            swap_seen    = bus.swap_sel;
            special_seen = bus.special;
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
            chk("ready_after_done", {31'd0, bus.ready}, 1);
            chk("ov_clear_after_done", {31'd0, bus.out_valid}, 0);
            chk("swap_clear", {31'd0, bus.swap_sel}, 0);
            chk("special_clear", {31'd0, bus.special}, 0);
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        bus.exp_a     = '0;
        bus.exp_b     = '0;
        bus.sum_carry = 1'b0;
        bus.sum_zero  = 1'b0;
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        chk("rst_ready", {31'd0, bus.ready}, 1);
        chk("rst_outs", {22'd0, bus.load_en, bus.swap_sel, bus.align_shift, bus.add_en,
                         bus.norm_right, bus.norm_left, bus.special, bus.result_we,
                         bus.out_valid, 1'b0}, 0);
        $display("step reset: ready=%0d", bus.ready);

        // Equal exponents, already normalized
        run_op(8'd127, 8'd127, 1'b0, 1'b0, 0, 0, 0);
        $display("op eq: align=%0d add=%0d nl=%0d nr=%0d we=+%0d ov=+%0d", n_align, n_add, n_nl, n_nr, we_cyc - acc, ov_cyc - acc);
        chk("eq_align", n_align, 0);
        chk("eq_add", n_add, 1);
        chk("eq_norm", n_nl + n_nr, 0);
        chk("eq_we_count", n_we, 1);
        chk("eq_we_lat", we_cyc - acc, 4);
        chk("eq_ov_lat", ov_cyc - acc, 5);
        chk("eq_swap", {31'd0, swap_seen}, 0);

        // A larger by 3
        run_op(8'd130, 8'd127, 1'b0, 1'b0, 0, 0, 0);
        $display("op a>b: align=%0d swap=%0d ov=+%0d", n_align, swap_seen, ov_cyc - acc);
        chk("agtb_align", n_align, 3);
        chk("agtb_swap", {31'd0, swap_seen}, 0);
        chk("agtb_ov_lat", ov_cyc - acc, 8);

        // B larger by 100: shift count saturates
        run_op(8'd100, 8'd200, 1'b0, 1'b0, 0, 0, 0);
        $display("op b>a: align=%0d swap=%0d ov=+%0d", n_align, swap_seen, ov_cyc - acc);
        chk("sat_align", n_align, 25);
        chk("sat_swap", {31'd0, swap_seen}, 1);
        chk("sat_we_lat", we_cyc - acc, 29);
        chk("sat_ov_lat", ov_cyc - acc, 30);

        // Carry out, consumer stalls 5 cycles
        run_op(8'd127, 8'd127, 1'b1, 1'b0, 0, 5, 0);
        $display("op carry: nr=%0d nl=%0d ov=+%0d n_ov=%0d", n_nr, n_nl, ov_cyc - acc, n_ov);
        chk("carry_nr", n_nr, 1);
        chk("carry_nl", n_nl, 0);
        chk("carry_ov_lat", ov_cyc - acc, 5);
        chk("carry_ov_cycles", n_ov, 6);

        // Four left shifts before the hidden bit appears
        run_op(8'd127, 8'd127, 1'b0, 1'b0, 4, 0, 0);
        $display("op left4: nl=%0d ov=+%0d", n_nl, ov_cyc - acc);
        chk("left4_nl", n_nl, 4);
        chk("left4_nr", n_nr, 0);
        chk("left4_ov_lat", ov_cyc - acc, 9);

        // Zero sum beats carry and missing MSB
        run_op(8'd127, 8'd127, 1'b1, 1'b1, 99, 0, 0);
        $display("op zero: nl=%0d nr=%0d we=+%0d", n_nl, n_nr, we_cyc - acc);
        chk("zero_norm", n_nl + n_nr, 0);
        chk("zero_we_lat", we_cyc - acc, 4);

        // MSB never set: left shifts cap out; start poked mid-NORM
        run_op(8'd127, 8'd127, 1'b0, 1'b0, 99, 0, 10);
        $display("op leftmax: nl=%0d load=%0d ov=+%0d", n_nl, n_load, ov_cyc - acc);
        chk("max_nl", n_nl, 23);
        chk("max_ov_lat", ov_cyc - acc, 28);
        chk("max_load_once", n_load, 1);

        // Special operand in A
        run_op(8'd255, 8'd3, 1'b0, 1'b0, 0, 0, 0);
        $display("op special: special=%0d align=%0d add=%0d we=+%0d ov=+%0d", special_seen, n_align, n_add, we_cyc - acc, ov_cyc - acc);
        chk("spec_flag", {31'd0, special_seen}, 1);
        chk("spec_strobes", n_align + n_add + n_nl + n_nr, 0);
        chk("spec_we_lat", we_cyc - acc, 2);
        chk("spec_ov_lat", ov_cyc - acc, 3);

        // Special operand in B: swap select stays low
        run_op(8'd3, 8'd255, 1'b0, 1'b0, 0, 0, 0);
        $display("op special_b: special=%0d swap=%0d", special_seen, swap_seen);
        chk("specb_flag", {31'd0, special_seen}, 1);
        chk("specb_swap", {31'd0, swap_seen}, 0);

        // Reset in the middle of alignment
        @(posedge clk); #1;
        clear_counts();
        bus.exp_a = 8'd100;
        bus.exp_b = 8'd200;
        bus.sum_carry = 1'b0;
        bus.sum_zero  = 1'b0;
        msb_after = 0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_in_align", {31'd0, bus.align_shift}, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_ready", {31'd0, bus.ready}, 1);
        chk("abort_outs", {23'd0, bus.swap_sel, bus.align_shift, bus.add_en, bus.norm_right,
                           bus.norm_left, bus.special, bus.result_we, bus.out_valid, 1'b0}, 0);
        repeat (40) @(posedge clk);
        #1;
        $display("op abort: we=%0d ov=%0d ready=%0d", n_we, n_ov, bus.ready);
        chk("abort_no_we", n_we, 0);
        chk("abort_no_ov", n_ov, 0);

        // Normal operation right after the abort
        run_op(8'd130, 8'd127, 1'b0, 1'b0, 0, 0, 0);
        $display("op post_abort: align=%0d ov=+%0d", n_align, ov_cyc - acc);
        chk("post_align", n_align, 3);
        chk("post_ov_lat", ov_cyc - acc, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
